// File: rtl/elastic_pipe_buffer_if.sv
// ---------------------------------------------------------------------------
// elastic_pipe_buffer_if
//
// Purpose : valid/ready/data handshake bundle used on both sides of
//           elastic_pipe_buffer.
//
// Signals : valid  - source has a payload this cycle
//           ready  - sink can take the payload this cycle
//           data   - payload of type T
//
// Modports: master - drives valid/data, observes ready (the data source)
//           slave  - observes valid/data, drives ready (the data sink)
// ---------------------------------------------------------------------------
interface elastic_pipe_buffer_if #(
  parameter type T = logic [31:0]
) ();

  logic valid;
  logic ready;
  T     data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/elastic_pipe_buffer.sv
// ---------------------------------------------------------------------------
// elastic_pipe_buffer
//
// Purpose : DEPTH-entry elastic FIFO between pipeline stages. ready on the
//           input side depends only on registered state plus flush/reset, so
//           there is no combinational path from the consumer's ready to the
//           producer's ready. Supports a pipeline flush and reports occupancy
//           and almost-full for upstream throttling.
//
// Ports   : clk          - clock, all state updates on posedge
//           reset        - synchronous, active-high
//           flush        - synchronous discard of all entries
//           in_if        - slave side: valid/data from producer, ready back
//           out_if       - master side: valid/data to consumer, ready back
//           count        - current occupancy (0..DEPTH)
//           almost_full  - count >= AF_THRESH
//
// Options : ELASTIC_BYPASS_EN - when defined, an empty buffer forwards the
//           input straight to the output in the same cycle (zero latency).
//           When undefined, minimum latency is one cycle.
// ---------------------------------------------------------------------------
module elastic_pipe_buffer #(
  parameter type T         = logic [31:0],
  parameter int  DEPTH     = 4,
  parameter int  AF_THRESH = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  elastic_pipe_buffer_if.slave       in_if,
  elastic_pipe_buffer_if.master      out_if,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       almost_full
);

  localparam int IW = $clog2(DEPTH);      // index bits
  localparam int PW = IW + 1;             // index bits plus wrap bit
  localparam int CW = $clog2(DEPTH + 1);  // occupancy width

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];

  logic [IW-1:0] wr_idx, rd_idx;
  logic          empty, full;
  logic          valid_in, ready_in, valid_out, ready_out;
  T              data_in, data_out;
  logic          push, pop, wr_en, rd_en;

  assign valid_in     = in_if.valid;
  assign data_in      = in_if.data;
  assign ready_out    = out_if.ready;
  assign in_if.ready  = ready_in;
  assign out_if.valid = valid_out;
  assign out_if.data  = data_out;

  assign wr_idx = wr_ptr_q[IW-1:0];
  assign rd_idx = rd_ptr_q[IW-1:0];

  // Same index with opposite wrap bits means the writer is a full lap ahead.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);

  // Handshake and output selection
  always_comb begin
    // Registered-full only: a pop this cycle never frees a slot for a push
    // this cycle, which keeps ready_in off the consumer's ready path.
    ready_in = !full && !flush && !reset;
`ifdef ELASTIC_BYPASS_EN
    // Empty buffer: present the producer's word directly.
    valid_out = !flush && !reset && (empty ? valid_in : 1'b1);
    data_out  = empty ? data_in : mem_q[rd_idx];
`else
    valid_out = !empty && !flush && !reset;
    data_out  = mem_q[rd_idx];
`endif
    push = valid_in && ready_in;
    pop  = valid_out && ready_out;
`ifdef ELASTIC_BYPASS_EN
    // A word consumed by cut-through never touches storage or pointers.
    wr_en = push && !(empty && ready_out);
    rd_en = pop && !empty;
`else
    wr_en = push;
    rd_en = pop;
`endif
  end

  // Next-state computation
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_idx] = data_in;
        wr_ptr_d      = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
    // Modulo 2*DEPTH difference is exactly the occupancy.
    count_d = CW'(wr_ptr_d - rd_ptr_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (reset) begin
        mem_q[gi] <= '0;
      end else begin
        mem_q[gi] <= mem_d[gi];
      end
    end
  end

  assign count       = count_q;
  assign almost_full = (count_q >= CW'(AF_THRESH));

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
// ---------------------------------------------------------------------------
// tb_elastic_pipe_buffer
//
// Purpose : self-checking bench for elastic_pipe_buffer (DEPTH=4,
//           AF_THRESH=3, 32-bit payload). Stimulus pushes each accepted word
//           into a scoreboard queue; a monitor pops and compares whenever the
//           DUT completes an output handshake. Status outputs are compared
//           against hand-computed constants at fixed points.
// ---------------------------------------------------------------------------
module tb_elastic_pipe_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [2:0] count;
  logic       almost_full;

  elastic_pipe_buffer_if #(.T(logic [31:0])) in_if ();
  elastic_pipe_buffer_if #(.T(logic [31:0])) out_if ();

  elastic_pipe_buffer #(
    .T         (logic [31:0]),
    .DEPTH     (4),
    .AF_THRESH (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_if       (in_if),
    .out_if      (out_if),
    .count       (count),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

`ifdef ELASTIC_BYPASS_EN
  localparam logic [2:0] STREAM_END_COUNT = 3'd0;
`else
  localparam logic [2:0] STREAM_END_COUNT = 3'd1;
`endif

  int          checks = 0;
  int          errors = 0;
  int          pop_count = 0;
  logic [31:0] last_popped = '0;
  logic [31:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Return to the drive phase, just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word; record it as expected once the handshake is seen.
  task automatic send(input logic [31:0] d, output int waited);
    in_if.valid = 1'b1;
    in_if.data  = d;
    waited      = 0;
    while (waited < 50) begin
      @(negedge clk);
      if (in_if.ready === 1'b1) begin
        sb.push_back(d);
        step();
        in_if.valid = 1'b0;
        return;
      end
      step();
      waited++;
    end
    in_if.valid = 1'b0;
    checks++;
    errors++;
    $display("FAIL send_timeout: got no ready expected ready for %h", d);
  endtask

  // Scoreboard monitor: samples just after the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (out_if.valid === 1'b1 && out_if.ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got %h expected no output", out_if.data);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        $display("pop #%0d data=%h expected=%h", pop_count, out_if.data, exp);
        check("pop_data", out_if.data, exp);
      end
      last_popped = out_if.data;
      pop_count++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    logic [2:0] exp_cnt;
    logic       exp_af [4];
    exp_af = '{1'b0, 1'b0, 1'b1, 1'b1};

    reset        = 1'b1;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    // ---- Reset then idle ----
    step();
    @(negedge clk);
    check("rst_ready_in_low", {31'd0, in_if.ready}, 32'd0);
    check("rst_valid_out_low", {31'd0, out_if.valid}, 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready_in", {31'd0, in_if.ready}, 32'd1);
    check("idle_valid_out", {31'd0, out_if.valid}, 32'd0);
    check("idle_count", {29'd0, count}, 32'd0);
    check("idle_data_out", out_if.data, 32'h0);
    check("idle_almost_full", {31'd0, almost_full}, 32'd0);
    step();

    // ---- Fill to full with consumer stalled ----
    for (int i = 0; i < 4; i++) begin
      send(32'h11 * (i + 1), w);
      @(negedge clk);
      exp_cnt = 3'(i + 1);
      check("fill_count", {29'd0, count}, {29'd0, exp_cnt});
      check("fill_almost_full", {31'd0, almost_full}, {31'd0, exp_af[i]});
      step();
    end
    @(negedge clk);
    check("full_ready_in", {31'd0, in_if.ready}, 32'd0);
    check("full_valid_out", {31'd0, out_if.valid}, 32'd1);
    step();

    // ---- Drain, one per cycle ----
    out_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drain_valid_out", {31'd0, out_if.valid}, 32'd1);
      exp_cnt = 3'(4 - k);
      check("drain_count", {29'd0, count}, {29'd0, exp_cnt});
      step();
    end
    @(negedge clk);
    check("drained_count", {29'd0, count}, 32'd0);
    check("drained_valid_out", {31'd0, out_if.valid}, 32'd0);
    step();

    // ---- Steady stream, consumer always ready ----
    for (int i = 0; i < 16; i++) begin
      send(32'h100 + i, w);
      check("stream_stall", w, 32'd0);
    end
    @(negedge clk);
    check("stream_end_count", {29'd0, count}, {29'd0, STREAM_END_COUNT});
    step();
    @(negedge clk);
    check("stream_drained_count", {29'd0, count}, 32'd0);
    step();

    // ---- Full buffer with valid_in and ready_out both high ----
    out_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h200 + i, w);
    in_if.valid  = 1'b1;
    in_if.data   = 32'hDEAD;
    out_if.ready = 1'b1;
    @(negedge clk);
    check("full_pop_ready_in", {31'd0, in_if.ready}, 32'd0);
    step();
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    @(negedge clk);
    check("full_pop_count", {29'd0, count}, 32'd3);
    step();

    // ---- Flush at count 3 with both sides requesting ----
    flush        = 1'b1;
    in_if.valid  = 1'b1;
    in_if.data   = 32'hBEEF;
    out_if.ready = 1'b1;
    @(negedge clk);
    check("flush_ready_in", {31'd0, in_if.ready}, 32'd0);
    check("flush_valid_out", {31'd0, out_if.valid}, 32'd0);
    step();
    flush       = 1'b0;
    in_if.valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("post_flush_count", {29'd0, count}, 32'd0);
    check("post_flush_valid_out", {31'd0, out_if.valid}, 32'd0);
    check("post_flush_ready_in", {31'd0, in_if.ready}, 32'd1);
    check("post_flush_almost_full", {31'd0, almost_full}, 32'd0);
    step();

    // ---- Reset mid-stream at count 2 ----
    out_if.ready = 1'b0;
    send(32'h300, w);
    send(32'h301, w);
    @(negedge clk);
    check("pre_reset_count", {29'd0, count}, 32'd2);
    step();
    reset        = 1'b1;
    out_if.ready = 1'b1;
    in_if.data   = '0;
    @(negedge clk);
    check("mid_rst_valid_out", {31'd0, out_if.valid}, 32'd0);
    check("mid_rst_ready_in", {31'd0, in_if.ready}, 32'd0);
    step();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check("post_rst_count", {29'd0, count}, 32'd0);
    check("post_rst_valid_out", {31'd0, out_if.valid}, 32'd0);
    check("post_rst_data_out", out_if.data, 32'h0);
    step();
    send(32'hAA, w);
    step();
    step();
    @(negedge clk);
    #2;
    check("first_after_reset", last_popped, 32'hAA);
    check("total_pops", pop_count, 32'd22);
    check("scoreboard_empty", sb.size(), 32'd0);
    check("final_count", {29'd0, count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
